// File: rtl/mul4_seq_pkg.sv
// mul4_seq_pkg: shared widths and FSM encoding for the sequential multiplier
package mul4_seq_pkg;
    localparam int WORD_W = 4;
    localparam int PROD_W = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mul4_seq_if.sv
// mul4_seq_if: start/busy/done handshake and operand/product bus
interface mul4_seq_if;
    import mul4_seq_pkg::*;
    logic start;
    logic [WORD_W-1:0] a, b;
    logic busy, done;
    logic [PROD_W-1:0] product;
    modport master (output start, a, b, input busy, done, product);
    modport slave (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mul4_seq_full_adder4.sv
// full_adder4: 4-bit adder with carry in and carry out
module full_adder4
    import mul4_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] s,
    output logic              cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
endmodule

// File: rtl/mul4_seq.sv
// mul4_seq: 4x4 unsigned shift-and-add multiplier, one adder pass per cycle
module mul4_seq
    import mul4_seq_pkg::*;
(
    input logic       clk,
    input logic       rst,
    mul4_seq_if.slave bus
);
    state_t            state;
    logic [WORD_W-1:0] m_reg, acc, q, addend, s;
    logic [1:0]        cnt;
    logic              c;
    assign addend = q[0] ? m_reg : '0;
    full_adder4 u_add (.a(acc), .b(addend), .cin(1'b0), .s(s), .cout(c));
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            m_reg <= '0;
            acc   <= '0;
            q     <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            // carry lands in acc[3] so no product bit is lost
            {acc, q} <= {c, s, q[WORD_W-1:1]};
            cnt      <= cnt + 2'd1;
            state    <= cnt == 2'd3 ? DONE : RUN;
        end else if (bus.start) begin
            m_reg <= bus.a;
            q     <= bus.b;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
        end else
            state <= IDLE;
    assign bus.busy    = state == RUN;
    assign bus.done    = state == DONE;
    assign bus.product = {acc, q};
endmodule

// File: tb/tb_mul4_seq.sv
// tb_mul4_seq: directed checks of mul4_seq timing, handshake and arithmetic
module tb_mul4_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    mul4_seq_if bus();
    mul4_seq dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [3:0] x, input logic [3:0] y, input logic [7:0] want, input bit full);
        bus.a = x;
        bus.b = y;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (full) chk("busy_run", {7'd0, bus.busy}, 8'd1);
            chk("done_early", {7'd0, bus.done}, 8'd0);
            step();
        end
        chk("done_pulse", {7'd0, bus.done}, 8'd1);
        chk("product", bus.product, want);
        if (full) chk("busy_in_done", {7'd0, bus.busy}, 8'd0);
        step();
        chk("done_once", {7'd0, bus.done}, 8'd0);
        if (full) chk("product_idle", bus.product, want);
    endtask

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: time %0t reached limit 100000", $time);
    end

    initial begin
        bus.start = 1'b0;
        bus.a = 4'h0;
        bus.b = 4'h0;
        step();
        step();
        chk("rst_busy", {7'd0, bus.busy}, 8'd0);
        chk("rst_done", {7'd0, bus.done}, 8'd0);
        chk("rst_product", bus.product, 8'h00);
        rst = 1'b0;
        step();
        chk("idle_done", {7'd0, bus.done}, 8'd0);

        run(4'hF, 4'hF, 8'hE1, 1'b1);
        step();
        chk("hold_e1", bus.product, 8'hE1);
        run(4'h0, 4'hB, 8'h00, 1'b1);
        run(4'h9, 4'h1, 8'h09, 1'b1);
        run(4'h1, 4'h9, 8'h09, 1'b1);
        run(4'hD, 4'hA, 8'h82, 1'b1);

        bus.a = 4'h7;
        bus.b = 4'h6;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("ign_busy1", {7'd0, bus.busy}, 8'd1);
        step();
        bus.start = 1'b1;
        bus.a = 4'hF;
        bus.b = 4'hF;
        chk("ign_busy2", {7'd0, bus.busy}, 8'd1);
        step();
        chk("ign_busy3", {7'd0, bus.busy}, 8'd1);
        step();
        bus.start = 1'b0;
        chk("ign_busy4", {7'd0, bus.busy}, 8'd1);
        chk("ign_no_done", {7'd0, bus.done}, 8'd0);
        step();
        chk("ign_done", {7'd0, bus.done}, 8'd1);
        chk("ign_product", bus.product, 8'h2A);
        step();
        chk("ign_done_once", {7'd0, bus.done}, 8'd0);
        chk("ign_hold", bus.product, 8'h2A);

        bus.a = 4'h3;
        bus.b = 4'h5;
        bus.start = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                chk("b2b_busy", {7'd0, bus.busy}, 8'd1);
                chk("b2b_no_done", {7'd0, bus.done}, 8'd0);
                step();
            end
            chk("b2b_done", {7'd0, bus.done}, 8'd1);
            chk("b2b_busy_low", {7'd0, bus.busy}, 8'd0);
            chk("b2b_product", bus.product, 8'h0F);
            step();
        end
        bus.start = 1'b0;
        repeat (5) step();
        chk("b2b_drained", {7'd0, bus.busy}, 8'd0);

        bus.a = 4'hF;
        bus.b = 4'hF;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("pre_rst_busy", {7'd0, bus.busy}, 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", {7'd0, bus.busy}, 8'd0);
        chk("async_done", {7'd0, bus.done}, 8'd0);
        chk("async_product", bus.product, 8'h00);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_no_done", {7'd0, bus.done}, 8'd0);
            step();
        end
        run(4'h5, 4'h5, 8'h19, 1'b1);

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                run(4'(i), 4'(j), 8'(i * j), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
